limbus_sysid_checker: RTL and testbench

LIMBUS_SYSID_CHECKER -- requirements
Module: limbus_sysid_checker

---
 rtl/limbus_sysid_checker.sv | 143 ++++++++++++++
 tb/tb_limbus_sysid_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/limbus_sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them to expected constants.
// Latency: done pulses 3 cycles after start with a zero-wait slave, plus one cycle per wait state.
// Backpressure: each read holds address/read while waitrequest is high, aborting after TIMEOUT_CYCLES stalls.
module limbus_sysid_checker #(
  parameter logic [31:0] EXP_ID         = 32'd0,
  parameter logic [31:0] EXP_TIMESTAMP  = 32'd1383563533,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        err_id,
  output logic        err_ts,
  output logic        err_timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  // A read times out on the stall cycle in which the counter already holds TIMEOUT_CYCLES-1,
  // i.e. exactly TIMEOUT_CYCLES consecutive waitrequest cycles are tolerated before giving up.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        pass_q, pass_d;
  logic        err_id_q, err_id_d;
  logic        err_ts_q, err_ts_d;
  logic        err_to_q, err_to_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        in_read;
  logic        timeout_hit;

  assign in_read     = (state_q == RD_ID) || (state_q == RD_TS);
  assign timeout_hit = in_read && avm_waitrequest && (wait_cnt_q == TO_LAST);

  // Next-state, capture and bus-control decode; the wait counter clears whenever a read is not stalling.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = 16'd0;
    pass_d      = pass_q;
    err_id_d    = err_id_q;
    err_ts_d    = err_ts_q;
    err_to_d    = err_to_q;
    id_d        = id_q;
    ts_d        = ts_q;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RD_ID;
          pass_d   = 1'b0;
          err_id_d = 1'b0;
          err_ts_d = 1'b0;
          err_to_d = 1'b0;
        end
      end
      RD_ID: begin
        busy     = 1'b1;
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          id_d     = avm_readdata;
          err_id_d = (avm_readdata != EXP_ID);
          state_d  = RD_TS;
        end else if (timeout_hit) begin
          err_to_d = 1'b1;
          state_d  = FINISH;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      RD_TS: begin
        busy        = 1'b1;
        avm_read    = 1'b1;
        avm_address = 1'b1;
        if (!avm_waitrequest) begin
          ts_d     = avm_readdata;
          err_ts_d = (avm_readdata != EXP_TIMESTAMP);
          state_d  = FINISH;
        end else if (timeout_hit) begin
          err_to_d = 1'b1;
          state_d  = FINISH;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      FINISH: begin
        done    = 1'b1;
        pass_d  = ~(err_id_q | err_ts_q | err_to_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset wins over everything, including a concurrent start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 16'd0;
      pass_q     <= 1'b0;
      err_id_q   <= 1'b0;
      err_ts_q   <= 1'b0;
      err_to_q   <= 1'b0;
      id_q       <= 32'd0;
      ts_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pass_q     <= pass_d;
      err_id_q   <= err_id_d;
      err_ts_q   <= err_ts_d;
      err_to_q   <= err_to_d;
      id_q       <= id_d;
      ts_q       <= ts_d;
    end
  end

  assign pass        = pass_q;
  assign err_id      = err_id_q;
  assign err_ts      = err_ts_q;
  assign err_timeout = err_to_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_limbus_sysid_checker.sv
// Directed bench for limbus_sysid_checker: nominal, ID mismatch, stalls, timeout, ignored start, reset abort.
// Two instances: default parameters, and TIMEOUT_CYCLES=4 for the timeout case.
// Inputs driven and outputs sampled on the falling edge.
module tb_limbus_sysid_checker;

  localparam logic [31:0] TS = 32'd1383563533;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start_b;
  logic        wr, wr_b;
  logic [31:0] id_word, ts_word;

  logic        addr, rd, busy, done, pass, e_id, e_ts, e_to;
  logic [31:0] rdata, idv, tsv;
  logic        addr_b, rd_b, busy_b, done_b, pass_b, e_id_b, e_ts_b, e_to_b;
  logic [31:0] rdata_b, idv_b, tsv_b;

  int checks = 0;
  int errors = 0;

  // Sysid slave model: word 0 is the ID, word 1 the timestamp.
  assign rdata   = addr   ? ts_word : id_word;
  assign rdata_b = addr_b ? ts_word : id_word;

  limbus_sysid_checker dut (
    .clock(clk), .reset(reset), .start(start),
    .avm_address(addr), .avm_read(rd), .avm_readdata(rdata), .avm_waitrequest(wr),
    .busy(busy), .done(done), .pass(pass), .err_id(e_id), .err_ts(e_ts), .err_timeout(e_to),
    .id_value(idv), .ts_value(tsv)
  );

  limbus_sysid_checker #(.TIMEOUT_CYCLES(4)) dut_b (
    .clock(clk), .reset(reset), .start(start_b),
    .avm_address(addr_b), .avm_read(rd_b), .avm_readdata(rdata_b), .avm_waitrequest(wr_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_id(e_id_b), .err_ts(e_ts_b), .err_timeout(e_to_b),
    .id_value(idv_b), .ts_value(tsv_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns on the falling edge of the first cycle after start was sampled.
  task automatic pulse_a();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_b();
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
  endtask

  // Called in cycle 1 of a sequence; n is the cycle index at which done is seen (bounded).
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int extra;
    int busy_seen;
    reset = 1'b1; start = 1'b0; start_b = 1'b0;
    wr = 1'b0; wr_b = 1'b0; id_word = 32'd0; ts_word = TS;

    // Reset overrides a concurrent start
    @(negedge clk) begin start = 1'b1; start_b = 1'b1; end
    @(negedge clk) begin start = 1'b0; start_b = 1'b0; end
    chk("reset_ctrl", {busy, done, pass, e_id, e_ts, e_to, rd, addr}, 32'd0);
    chk("reset_id", idv, 32'd0);
    chk("reset_ts", tsv, 32'd0);
    chk("reset_ctrl_b", {busy_b, done_b, pass_b, e_id_b, e_ts_b, e_to_b, rd_b, addr_b}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_start", busy, 32'd0);

    // Nominal zero-wait sequence
    pulse_a();
    chk("nom_c1_busy", busy, 32'd1);
    chk("nom_c1_rd_addr", {rd, addr}, 32'b10);
    @(negedge clk);
    chk("nom_c2_rd_addr", {rd, addr}, 32'b11);
    @(negedge clk);
    chk("nom_c3_done_busy", {done, busy}, 32'b10);
    chk("nom_c3_rd_addr", {rd, addr}, 32'b00);
    @(negedge clk);
    chk("nom_done_once", done, 32'd0);
    chk("nom_pass_errs", {pass, e_id, e_ts, e_to}, 32'b1000);
    chk("nom_id", idv, 32'd0);
    chk("nom_ts", tsv, TS);

    // ID mismatch; timestamp is still read
    id_word = 32'd5;
    pulse_a();
    chk("idm_pass_cleared", pass, 32'd0);
    wait_done(n);
    chk("idm_latency", n, 32'd3);
    @(negedge clk);
    chk("idm_pass_errs", {pass, e_id, e_ts, e_to}, 32'b0100);
    chk("idm_id", idv, 32'd5);
    chk("idm_ts", tsv, TS);

    // Ten wait states on the ID read
    id_word = 32'd0;
    wr = 1'b1;
    pulse_a();
    chk("idm_err_cleared", e_id, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      chk("stall_rd_addr_busy", {rd, addr, busy}, 32'b101);
      @(negedge clk);
    end
    chk("stall_c11_addr", {rd, addr}, 32'b10);
    wr = 1'b0;
    n = 11;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall_latency", n, 32'd13);
    @(negedge clk);
    chk("stall_pass_errs", {pass, e_id, e_ts, e_to}, 32'b1000);
    chk("stall_id", idv, 32'd0);

    // Start re-pulsed during RD_TS is ignored; timestamp mismatch this time
    ts_word = 32'd1;
    pulse_a();
    @(negedge clk);
    chk("ign_in_rdts", {rd, addr}, 32'b11);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_done", done, 32'd1);
    extra = 0;
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      extra += int'(done);
      busy_seen += int'(busy);
    end
    chk("ign_no_extra_done", extra, 32'd0);
    chk("ign_no_requeue", busy_seen, 32'd0);
    chk("ign_pass_errs", {pass, e_id, e_ts, e_to}, 32'b0010);
    chk("ign_ts", tsv, 32'd1);

    // Fresh start after done clears flags and completes
    ts_word = TS;
    pulse_a();
    chk("restart_cleared", {pass, e_id, e_ts, e_to}, 32'b0000);
    wait_done(n);
    chk("restart_latency", n, 32'd3);
    @(negedge clk);
    chk("restart_pass", {pass, e_ts}, 32'b10);
    chk("restart_ts", tsv, TS);

    // Reset during a stalled RD_TS aborts with no done
    pulse_a();
    @(negedge clk);
    chk("rst_in_rdts", {rd, addr}, 32'b11);
    wr = 1'b1;
    @(negedge clk);
    chk("rst_stall_c3", {done, busy, addr}, 32'b011);
    @(negedge clk);
    chk("rst_stall_c4", {done, rd}, 32'b01);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ctrl", {busy, done, pass, e_id, e_ts, e_to, rd, addr}, 32'd0);
    chk("rst_ts", tsv, 32'd0);
    chk("rst_id", idv, 32'd0);
    reset = 1'b0;
    wr = 1'b0;
    @(negedge clk);
    chk("rst_no_done", {done, busy}, 32'b00);
    pulse_a();
    wait_done(n);
    chk("rst_after_latency", n, 32'd3);
    @(negedge clk);
    chk("rst_after_pass", {pass, e_id, e_ts, e_to}, 32'b1000);
    chk("rst_after_ts", tsv, TS);

    // Timeout on the ID read with TIMEOUT_CYCLES=4
    wr_b = 1'b1;
    pulse_b();
    for (int i = 1; i <= 4; i++) begin
      chk("to_wait_rd_busy", {rd_b, addr_b, busy_b, done_b}, 32'b1010);
      @(negedge clk);
    end
    chk("to_c5_done", {done_b, busy_b, rd_b}, 32'b100);
    chk("to_c5_err", e_to_b, 32'd1);
    @(negedge clk);
    chk("to_pass_errs", {pass_b, e_id_b, e_ts_b, e_to_b}, 32'b0001);
    chk("to_ts_untouched", tsv_b, 32'd0);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      extra += int'(done_b) + int'(rd_b);
    end
    chk("to_single_done", extra, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
